// File: rtl/wr_uart_rx_capture.sv
// wr_uart_rx_capture: 8N1 UART receiver feeding a show-ahead byte FIFO.
// Flags framing errors, FIFO overflow (sticky) and end-of-line (0x0A) pushes.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity check).
module wr_uart_rx_capture #(
    parameter int g_clk_freq_hz = 125000000,
    parameter int g_baud        = 115200,
    parameter int g_fifo_depth  = 16
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_i,
    input  logic                          rxd_i,
    input  logic                          rd_i,
    input  logic                          clr_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    output logic [$clog2(g_fifo_depth):0] count_o,
    output logic                          eol_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o
);

    localparam int C_CPB = g_clk_freq_hz / g_baud;
    localparam int C_TW  = $clog2(C_CPB);
    localparam int C_AW  = $clog2(g_fifo_depth);
    localparam logic [C_TW-1:0] C_T_FULL = C_TW'(C_CPB - 1);
    localparam logic [C_TW-1:0] C_T_HALF = C_TW'(C_CPB / 2 - 1);
    localparam logic [C_AW:0]   C_DEPTH  = (C_AW+1)'(g_fifo_depth);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    logic            r_sync1, r_sync2;
    state_t          r_state, w_state_next;
    logic [C_TW-1:0] r_timer, w_timer_next;
    logic [3:0]      r_bit_cnt, w_bit_cnt_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_par_bad, w_par_bad_next;
    logic            w_push, w_ferr, w_rxs;
`ifdef UART_RX_PARITY_EN
    logic            w_perr, r_perr;
`endif

    logic [7:0]      r_mem [g_fifo_depth];
    logic [C_AW-1:0] r_wptr, r_rptr;
    logic [C_AW:0]   r_count;
    logic            r_eol, r_ferr, r_ovf;
    logic            w_full, w_pop, w_wr, w_drop;

    assign w_rxs = r_sync2;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register together with its bit timer and shift register.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_par_bad <= w_par_bad_next;
        end
    end

    // Next-state logic: mid-bit sampling, start-bit glitch rejection, break hold-off.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer + 1'b1;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_bad_next = r_par_bad;
        w_push         = 1'b0;
        w_ferr         = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr         = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (!w_rxs) w_state_next = S_START;
            end
            S_START: begin
                if (r_timer == C_T_HALF) begin
                    w_timer_next = '0;
                    if (w_rxs) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_DATA;
                        w_bit_cnt_next = '0;
                        w_par_bad_next = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (r_timer == C_T_FULL) begin
                    w_timer_next   = '0;
                    w_shift_next   = {w_rxs, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PAR;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: begin
                if (r_timer == C_T_FULL) begin
                    w_timer_next   = '0;
                    w_par_bad_next = (^r_shift) ^ w_rxs;
                    w_perr         = (^r_shift) ^ w_rxs;
                    w_state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_timer == C_T_FULL) begin
                    w_timer_next = '0;
                    if (w_rxs) begin
                        w_state_next = S_IDLE;
                        w_push       = !r_par_bad;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = S_BRK;
                    end
                end
            end
            S_BRK: begin
                w_timer_next = '0;
                if (w_rxs) w_state_next = S_IDLE;
            end
            default: begin
                w_timer_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_full = (r_count == C_DEPTH);
    assign w_pop  = rd_i && valid_o;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // FIFO storage; the head is read combinationally to give show-ahead behaviour.
    always_ff @(posedge clk_sys_i) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Status pulses and sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_eol  <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_eol  <= w_wr && (r_shift == 8'h0A);
            r_ferr <= w_ferr;
            if (w_drop)     r_ovf <= 1'b1;
            else if (clr_i) r_ovf <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse, emitted the cycle after the parity bit sample.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) r_perr <= 1'b0;
        else       r_perr <= w_perr;
    end
    assign parity_err_o = r_perr;
`else
    assign parity_err_o = 1'b0;
`endif

    assign valid_o     = (r_count != '0);
    assign data_o      = valid_o ? r_mem[r_rptr] : 8'h00;
    assign count_o     = r_count;
    assign eol_o       = r_eol;
    assign frame_err_o = r_ferr;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_wr_uart_rx_capture.sv
// Scoreboard bench for wr_uart_rx_capture: CPB=10, FIFO depth 4.
module tb_wr_uart_rx_capture;

    logic       clk = 1'b0;
    logic       rst, rxd, rd_i, clr;
    logic [7:0] data_o;
    logic       valid_o, eol_o, frame_err_o, parity_err_o, overflow_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;
    int eol_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    bit rd_en = 1'b0;
    bit pop_req = 1'b0;
    logic [7:0] exp_q[$];

    wr_uart_rx_capture #(
        .g_clk_freq_hz(1000000),
        .g_baud       (100000),
        .g_fifo_depth (4)
    ) dut (
        .clk_sys_i   (clk),
        .rst_i       (rst),
        .rxd_i       (rxd),
        .rd_i        (rd_i),
        .clr_i       (clr),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .eol_o       (eol_o),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: pop the FIFO head whenever reads are enabled and compare to the scoreboard.
    initial rd_i = 1'b0;
    always @(negedge clk) begin
        rd_i = 1'b0;
        if (!rst && valid_o && (rd_en || pop_req)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no byte", data_o);
            end else begin
                check("rx_byte", int'(data_o), int'(exp_q.pop_front()));
            end
            rd_i = 1'b1;
        end
    end

    // Pulse counters for the one-cycle status outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (eol_o)        eol_cnt++;
            if (frame_err_o)  ferr_cnt++;
            if (parity_err_o) perr_cnt++;
        end
    end

    // Drive one frame; stop_low>0 holds the stop bit low for that many cycles.
    task automatic send(input logic [7:0] b, input int stop_low, input bit exp_ok, input bit par_flip);
        if (exp_ok) exp_q.push_back(b);
        @(posedge clk); #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (10) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rxd = (^b) ^ par_flip;
        repeat (10) @(posedge clk);
`endif
        if (stop_low > 0) begin
            #1 rxd = 1'b0;
            repeat (stop_low) @(posedge clk);
        end
        #1 rxd = 1'b1;
        repeat (15) @(posedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int e0, f0, p0;
        rxd = 1'b1; rst = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_data", data_o, 0);
        check("rst_eol", eol_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_perr", parity_err_o, 0);
        check("rst_ovf", overflow_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single byte with exact latency: valid appears 98 cycles after the start edge.
        fork
            send(8'h55, 0, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                @(negedge clk);
                check("lat_valid_early", valid_o, 0);
                @(posedge clk);
                @(negedge clk);
                check("lat_valid", valid_o, 1);
                check("lat_data", data_o, 8'h55);
                check("lat_count", count_o, 1);
            end
        join
        check("x55_ferr", ferr_cnt, 0);
        check("x55_eol", eol_cnt, 0);
        rd_en = 1'b1;
        wait_drain();
        @(negedge clk);
        check("x55_empty", count_o, 0);

        // "OK\n" line with one end-of-line pulse.
        e0 = eol_cnt;
        send(8'h4F, 0, 1'b1, 1'b0);
        send(8'h4B, 0, 1'b1, 1'b0);
        send(8'h0A, 0, 1'b1, 1'b0);
        wait_drain();
        check("ok_eol_pulses", eol_cnt - e0, 1);

        // Framing error with a long low stop bit, then a clean byte.
        rd_en = 1'b0;
        f0 = ferr_cnt;
        send(8'hA3, 30, 1'b0, 1'b0);
        @(negedge clk);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_count", count_o, 0);
        rd_en = 1'b1;
        send(8'h31, 0, 1'b1, 1'b0);
        wait_drain();

        // Short glitch on the idle line.
        f0 = ferr_cnt; e0 = eol_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (120) @(posedge clk);
        @(negedge clk);
        check("glitch_count", count_o, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_eol", eol_cnt - e0, 0);

        // Overflow: five bytes into a depth-4 FIFO, then clear.
        rd_en = 1'b0;
        send(8'h11, 0, 1'b1, 1'b0);
        send(8'h12, 0, 1'b1, 1'b0);
        send(8'h13, 0, 1'b1, 1'b0);
        send(8'h14, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("full_ovf_before", overflow_o, 0);
        send(8'h15, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_count", count_o, 4);
        check("ovf_flag", overflow_o, 1);
        check("ovf_head", data_o, 8'h11);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow_o, 0);
        rd_en = 1'b1;
        wait_drain();
        rd_en = 1'b0;

        // Full FIFO with a pop coinciding with the fifth push: no overflow.
        send(8'h21, 0, 1'b1, 1'b0);
        send(8'h22, 0, 1'b1, 1'b0);
        send(8'h23, 0, 1'b1, 1'b0);
        send(8'h24, 0, 1'b1, 1'b0);
        fork
            send(8'h25, 0, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                pop_req = 1'b1;
                @(posedge clk); #1 pop_req = 1'b0;
            end
        join
        @(negedge clk);
        check("pp_count", count_o, 4);
        check("pp_ovf", overflow_o, 0);
        check("pp_head", data_o, 8'h22);
        rd_en = 1'b1;
        wait_drain();
        rd_en = 1'b0;

        // Reset in the middle of a frame with a byte already queued.
        send(8'h66, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", valid_o, 1);
        fork
            send(8'h7E, 0, 1'b0, 1'b0);
            begin
                @(posedge clk);
                repeat (40) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                check("mid_rst_valid", valid_o, 0);
                check("mid_rst_count", count_o, 0);
                check("mid_rst_data", data_o, 0);
                check("mid_rst_ferr", frame_err_o, 0);
            end
        join
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        rd_en = 1'b1;
        send(8'h12, 0, 1'b1, 1'b0);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        send(8'h03, 0, 1'b1, 1'b0);
        wait_drain();
        check("par_ok_perr", perr_cnt - p0, 0);
        rd_en = 1'b0;
        send(8'h03, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_count", count_o, 0);
        rd_en = 1'b1;
`else
        p0 = perr_cnt;
        check("perr_never", perr_cnt - p0 + int'(parity_err_o), 0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        check("final_valid", valid_o, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
